// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect input and
// the decoded-instruction output toward the control decoder.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [6:0]      op;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, op,
           instr_pc, instr_pc_plus4, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, op,
           instr_pc, instr_pc_plus4, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher; presents one word at a
// time to the decoder and zeroes instr/op whenever nothing valid is held.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] pc, ipc, ipc4;
  logic [31:0]     instr_q;
  logic            drop, vld, fault;

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = vld;
  assign bus.instr          = vld ? instr_q : '0;
  assign bus.op             = vld ? instr_q[6:0] : '0;
  assign bus.instr_pc       = ipc;
  assign bus.instr_pc_plus4 = ipc4;
  assign bus.fetch_fault    = fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      instr_q <= '0;
      ipc     <= '0;
      ipc4    <= '0;
      vld     <= 1'b0;
      fault   <= 1'b0;
    end else if (state != FAULT && bus.redirect_valid) begin
      vld <= 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fault <= 1'b1;
        state <= FAULT;
      end else begin
        pc <= bus.redirect_pc;
        // An in-flight request must have its response swallowed later via drop.
        case (state)
          IDLE, HOLD: state <= REQ;
          REQ: if (bus.imem_req_ready) begin
            state <= WAIT;
            drop  <= 1'b1;
          end
          WAIT: if (bus.imem_rsp_valid) begin
            state <= REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
          default: ;
        endcase
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:  if (bus.imem_req_ready) state <= WAIT;
        WAIT: if (bus.imem_rsp_valid) begin
          if (drop) begin
            drop  <= 1'b0;
            state <= REQ;
          end else begin
            instr_q <= bus.imem_rsp_data;
            ipc     <= pc;
            ipc4    <= pc + PC_STEP;
            pc      <= pc + PC_STEP;
            vld     <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: if (bus.instr_ready) begin
          vld   <= 1'b0;
          state <= REQ;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized fetch stream with redirects checked against an address-sequence
// model; a second instance checks PC wrap from a top-of-memory reset vector.
module tb_instr_fetch_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();
  instr_fetch_unit_if #(.XLEN(XLEN)) wbus ();

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(wbus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  // Memory contents as a pure function of address; address 0 holds 0x13.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  int   checks = 0;
  int   fails = 0;
  int   mode = 0;   // 0 reset, 1 directed, 2 random, 3 bad redirect, 4 fault watch
  bit   final_chk = 1'b0;
  exp_t exp_q[$];

  // ---------------- stimulus + memory ----------------
  logic        pend = 1'b0;
  int          lat = 0;
  logic [31:0] paddr = '0;
  bit          shot = 1'b0;
  logic        acc_seen = 1'b0, w_acc = 1'b0;
  logic [31:0] acc_addr = '0, w_addr = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend = 1'b0;
      shot = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (acc_seen) begin
        pend  = 1'b1;
        paddr = acc_addr;
        lat   = (mode == 2) ? int'($urandom_range(1, 3)) : 1;
      end
      if (pend) begin
        lat = lat - 1;
        if (lat == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(paddr);
          pend = 1'b0;
        end
      end
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      if (mode == 2) begin
        bus.imem_req_ready = ($urandom % 3) != 0;
        bus.instr_ready    = ($urandom % 4) != 0;
        if (($urandom % 14) == 0) begin
          bus.redirect_valid = 1'b1;
          case ($urandom % 4)
            0:       bus.redirect_pc = 32'h0000_0100;
            1:       bus.redirect_pc = 32'hFFFF_FFF8;
            default: bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
          endcase
        end
      end else begin
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        if (mode == 3 && !shot) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = 32'h0000_0102;
          shot = 1'b1;
        end
      end
      if (mode != 3) shot = 1'b0;
    end
  end

  // Wrap instance: always-ready memory with a one-cycle response.
  always @(posedge clk) begin
    #1;
    wbus.imem_req_ready = 1'b1;
    wbus.instr_ready    = 1'b1;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;
    wbus.imem_rsp_valid = w_acc;
    wbus.imem_rsp_data  = mem_word(w_addr);
  end

  // ---------------- reference model ----------------
  // The fetch stream is the sequential word sequence from the last aligned
  // redirect target (or the reset vector); a redirect discards the rest.
  logic [31:0] model_pc = '0;

  always @(negedge clk) begin
    acc_seen = rst_n && bus.imem_req_valid && bus.imem_req_ready;
    acc_addr = bus.imem_req_addr;
    w_acc    = rst_n && wbus.imem_req_valid && wbus.imem_req_ready;
    w_addr   = wbus.imem_req_addr;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      if (bus.redirect_valid && bus.redirect_pc[1:0] == 2'b00) begin
        exp_q.delete();
        model_pc = bus.redirect_pc;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  int          cyc = 0, first_req = -1, first_vld = -1, consumed = 0, w_cnt = 0;
  bit          final_done = 1'b0;
  logic        p_vld = 0, p_rdy = 0, p_redir = 0, p_req = 0, p_mrdy = 0, p_cons = 0;
  logic [31:0] p_instr = '0, p_ipc = '0, p_addr = '0, p_rpc = '0, p_cpc = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_addr", bus.imem_req_addr, 32'h0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_pcs", bus.instr_pc | bus.instr_pc_plus4, 0);
      chk("rst_fault", bus.fetch_fault, 0);
      chk("rst_wrap_addr", wbus.imem_req_addr, 32'hFFFF_FFFC);
      cyc = 0; first_req = -1; first_vld = -1;
      p_vld = 0; p_redir = 0; p_req = 0; p_cons = 0;
    end else begin
      if (bus.imem_req_valid && first_req < 0) first_req = cyc;
      if (bus.instr_valid && first_vld < 0) first_vld = cyc;
      cyc++;
      if (!bus.instr_valid) begin
        chk("bubble_instr", bus.instr, 0);
        chk("bubble_op", {25'b0, bus.op}, 0);
      end else begin
        chk("hold_no_req", bus.imem_req_valid, 0);
      end
      if (p_vld && !p_rdy && !p_redir) begin
        chk("hold_valid", bus.instr_valid, 1);
        chk("hold_instr", bus.instr, p_instr);
        chk("hold_pc", bus.instr_pc, p_ipc);
      end
      if (p_req && !p_mrdy && !p_redir) begin
        chk("req_held", bus.imem_req_valid, 1);
        chk("req_addr_held", bus.imem_req_addr, p_addr);
      end
      if (p_req && !p_mrdy && p_redir && p_rpc[1:0] == 2'b00) begin
        chk("req_retarget_valid", bus.imem_req_valid, 1);
        chk("req_retarget_addr", bus.imem_req_addr, p_rpc);
      end
      if (p_cons && !p_redir) begin
        chk("resume_req", bus.imem_req_valid, 1);
        chk("resume_addr", bus.imem_req_addr, p_cpc + 32'd4);
      end
      if (bus.imem_req_valid && bus.imem_req_ready)
        chk("one_outstanding", pend, 0);
      p_cons = 1'b0;
      if (bus.instr_valid && bus.instr_ready) begin
        consumed++;
        if (exp_q.size() == 0) begin
          chk("sb_queue_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.instr_pc, e.pc);
          chk("sb_instr", bus.instr, e.data);
          chk("sb_pc_plus4", bus.instr_pc_plus4, e.pc + 32'd4);
          chk("sb_op", {25'b0, bus.op}, {25'b0, e.data[6:0]});
          p_cons = 1'b1;
          p_cpc  = e.pc;
        end
      end
      if (mode == 4) begin
        chk("fault_flag", bus.fetch_fault, 1);
        chk("fault_no_req", bus.imem_req_valid, 0);
        chk("fault_instr_valid", bus.instr_valid, 0);
        chk("fault_instr", bus.instr, 0);
      end
      if (wbus.instr_valid && wbus.instr_ready && w_cnt < 2) begin
        chk("wrap_pc", wbus.instr_pc, (w_cnt == 0) ? 32'hFFFF_FFFC : 32'h0);
        chk("wrap_pc_plus4", wbus.instr_pc_plus4, (w_cnt == 0) ? 32'h0 : 32'h4);
        chk("wrap_instr", wbus.instr, mem_word((w_cnt == 0) ? 32'hFFFF_FFFC : 32'h0));
        w_cnt++;
      end
      p_vld   = bus.instr_valid;
      p_rdy   = bus.instr_ready;
      p_redir = bus.redirect_valid;
      p_rpc   = bus.redirect_pc;
      p_req   = bus.imem_req_valid;
      p_mrdy  = bus.imem_req_ready;
      p_addr  = bus.imem_req_addr;
      p_instr = bus.instr;
      p_ipc   = bus.instr_pc;
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      chk("first_req_cycle", first_req, 1);
      chk("first_valid_cycle", first_vld, 3);
      chk("consumed_enough", (consumed >= 100) ? 1 : 0, 1);
      chk("wrap_seen", w_cnt, 2);
    end
  end

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1; mode = 1;
    repeat (12) @(posedge clk);
    #3 mode = 2;
    repeat (3000) @(posedge clk);
    #3 mode = 3;
    repeat (2) @(posedge clk);
    #3 mode = 4;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; mode = 1;
    repeat (12) @(posedge clk);
    #3 mode = 2;
    repeat (200) @(posedge clk);
    #3 final_chk = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
